// File: rtl/sr_sequencer.sv
// sr_sequencer: a command FIFO feeding an IDLE/DRIVE/SETTLE FSM that
// drives the S/R inputs of a downstream RS flip-flop. After each drive
// it checks the flip-flop's Q feedback against the expected value.
// Optional feature macro: SR_SEQ_TOGGLE_EN enables toggle commands,
// which are resolved against Q_fb when they are popped. Without it, a
// toggle is popped and rejected with an err pulse.
module sr_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [1:0]       SR,
    input  logic             Q_fb,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

    logic [1:0]       op_mem  [DEPTH];
    logic [LEN_W-1:0] len_mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, push, pop;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;

    state_t           state_q, state_n;
    logic [LEN_W-1:0] cnt_q, cnt_n;
    logic [1:0]       drive_q, drive_n;
    logic             exp_q, exp_n;
    logic             chk_q, chk_n;
    logic [1:0]       sr_n;
    logic             done_n, err_n;

    // The extra pointer bit tells a full FIFO apart from an empty one
    // when the index bits are equal.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && !empty;
    assign head_op   = op_mem[rd_ptr[AW-1:0]];
    assign head_len  = len_mem[rd_ptr[AW-1:0]];
    assign busy      = (state_q != IDLE) || !empty;

    // Command storage; reset only needs to clear the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr[AW-1:0]]  <= cmd_op;
            len_mem[wr_ptr[AW-1:0]] <= cmd_len;
        end
    end

    // Next-state logic: resolve the op at pop, count the drive cycles, then judge the feedback.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        drive_n = drive_q;
        exp_n   = exp_q;
        chk_n   = chk_q;
        sr_n    = 2'b00;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_n = DRIVE;
                    cnt_n   = (head_len == '0) ? LEN_W'(1) : head_len;
                    case (head_op)
                        2'b10: begin
                            drive_n = 2'b10;
                            exp_n   = 1'b1;
                            chk_n   = 1'b1;
                        end
                        2'b01: begin
                            drive_n = 2'b01;
                            exp_n   = 1'b0;
                            chk_n   = 1'b1;
                        end
                        2'b11: begin
`ifdef SR_SEQ_TOGGLE_EN
                            drive_n = Q_fb ? 2'b01 : 2'b10;
                            exp_n   = !Q_fb;
                            chk_n   = 1'b1;
`else
                            drive_n = 2'b00;
                            exp_n   = 1'b0;
                            chk_n   = 1'b0;
                            state_n = IDLE;
                            err_n   = 1'b1;
`endif
                        end
                        default: begin
                            drive_n = 2'b00;
                            exp_n   = 1'b0;
                            chk_n   = 1'b0;
                        end
                    endcase
                    sr_n = (state_n == DRIVE) ? drive_n : 2'b00;
                end
            end
            DRIVE: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_n = SETTLE;
                    sr_n    = 2'b00;
                end else begin
                    cnt_n = cnt_q - LEN_W'(1);
                    sr_n  = drive_q;
                end
            end
            SETTLE: begin
                state_n = IDLE;
                if (!chk_q || (Q_fb == exp_q)) begin
                    done_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer and registered-output update; reset aborts any command silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            drive_q <= 2'b00;
            exp_q   <= 1'b0;
            chk_q   <= 1'b0;
            SR      <= 2'b00;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            drive_q <= drive_n;
            exp_q   <= exp_n;
            chk_q   <= chk_n;
            SR      <= sr_n;
            done    <= done_n;
            err     <= err_n;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_sr_sequencer.sv
// Directed testbench for sr_sequencer with a completion scoreboard and
// a behavioural RS flip-flop driving Q_fb. Expected toggle behaviour
// follows SR_SEQ_TOGGLE_EN.
module tb_sr_sequencer;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic [1:0]       SR;
    logic             Q_fb;
    logic             busy;
    logic             done;
    logic             err;

    int         total = 0;
    int         bad = 0;
    logic [1:0] sb [$];
    logic       qm;
    int         qmode;

    sr_sequencer #(.DEPTH(4), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .SR(SR), .Q_fb(Q_fb),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural downstream RS flip-flop.
    always @(posedge clk) begin
        if (rst) qm <= 1'b0;
        else if (SR == 2'b10) qm <= 1'b1;
        else if (SR == 2'b01) qm <= 1'b0;
    end

    // Feedback source: 0 = model flop, 1 = tied low, 2 = tied high.
    assign Q_fb = (qmode == 0) ? qm : ((qmode == 1) ? 1'b0 : 1'b1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        tick();
        tick();
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: every done/err pulse must match the next expected outcome; SR must never be 11.
    always @(negedge clk) begin
        logic [1:0] e;
        if (done || err) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pulse", 32'({done, err}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_outcome", 32'({done, err}), 32'(e));
            end
        end
        check("sr_never_11", 32'(SR == 2'b11), 32'd0);
    end

    initial begin
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        qmode     = 0;
        tick();
        tick();
        check("rst_sr", 32'(SR), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Set, length 3, model flop feedback.
        sb.push_back(2'b10);
        push_cmd(2'b10, 4'd3);
        check("set3_sr_pre", 32'(SR), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("set3_sr_drive", 32'(SR), 32'h2);
        end
        tick();
        check("set3_sr_settle", 32'(SR), 32'd0);
        tick();
        check("set3_done", 32'(done), 32'd1);
        check("set3_err", 32'(err), 32'd0);
        wait_idle("set3");

        // Toggle with Q_fb = 1 (left high by the previous set).
`ifdef SR_SEQ_TOGGLE_EN
        sb.push_back(2'b10);
        push_cmd(2'b11, 4'd1);
        tick();
        check("tog_sr_drive", 32'(SR), 32'h1);
        tick();
        check("tog_sr_settle", 32'(SR), 32'd0);
`else
        sb.push_back(2'b01);
        push_cmd(2'b11, 4'd1);
        tick();
        check("tog_sr_none", 32'(SR), 32'd0);
        check("tog_err", 32'(err), 32'd1);
`endif
        wait_idle("tog");

        // Long hold keeps the FSM busy while four resets fill the FIFO.
        sb.push_back(2'b10);
        push_cmd(2'b00, 4'd8);
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(cmd_ready), 32'd1);
            sb.push_back(2'b10);
            push_cmd(2'b01, 4'd1);
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        push_cmd(2'b10, 4'd1);
        wait_idle("fill");

        // Set, length 2, feedback stuck low.
        qmode = 1;
        sb.push_back(2'b01);
        push_cmd(2'b10, 4'd2);
        wait_idle("mismatch");
        qmode = 0;

        // Hold, length 0, feedback stuck high.
        qmode = 2;
        sb.push_back(2'b10);
        push_cmd(2'b00, 4'd0);
        check("hold0_sr_pre", 32'(SR), 32'd0);
        tick();
        check("hold0_sr_drive", 32'(SR), 32'd0);
        check("hold0_busy", 32'(busy), 32'd1);
        tick();
        check("hold0_sr_settle", 32'(SR), 32'd0);
        tick();
        check("hold0_done", 32'(done), 32'd1);
        wait_idle("hold0");
        qmode = 0;

        // Set with length 0 drives one cycle.
        sb.push_back(2'b10);
        push_cmd(2'b10, 4'd0);
        tick();
        check("set0_sr_drive", 32'(SR), 32'h2);
        tick();
        check("set0_sr_settle", 32'(SR), 32'd0);
        wait_idle("set0");

        // Maximum length drives for exactly 15 cycles.
        sb.push_back(2'b10);
        push_cmd(2'b10, 4'd15);
        n = 0;
        tick();
        while (SR == 2'b10 && n < 40) begin
            n++;
            tick();
        end
        check("set15_cycles", 32'(n), 32'd15);
        wait_idle("set15");

        // Reset in the 5th drive cycle, with a push offered alongside it.
        push_cmd(2'b10, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        check("abort_sr_before", 32'(SR), 32'h2);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = 4'd1;
        tick();
        cmd_valid = 1'b0;
        check("abort_sr", 32'(SR), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_sr_after", 32'(SR), 32'd0);
        tick();
        tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_sequencer.md
SR_SEQUENCER -- requirements
Module: sr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter LEN_W, default 4, meaning width of the per-command drive-length field.
REQ-003 clk  input  1  rising-edge clock for all state; one clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  a command is offered this cycle.
REQ-006 cmd_ready  output  1  the FIFO can accept a command this cycle.
REQ-007 cmd_op  input  2  operation code: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 cmd_len  input  LEN_W  number of cycles SR is driven; 0 is treated as 1.
REQ-009 SR  output  2  registered drive to the downstream RS flip-flop; SR[1]=S, SR[0]=R.
REQ-010 Q_fb  input  1  Q fed back from the downstream flip-flop.
REQ-011 busy  output  1  FSM is not in IDLE, or the FIFO is non-empty.
REQ-012 done  output  1  one-cycle pulse when a command completes without error.
REQ-013 err  output  1  one-cycle pulse on a feedback mismatch or a rejected command.

Function
REQ-014 SHALL enqueue {cmd_op, cmd_len} on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready = !full && !rst.
REQ-015 SHALL issue commands in FIFO order; a full FIFO with a simultaneous pop SHALL NOT accept a push in that cycle (cmd_ready is based on the registered full flag).
REQ-016 FSM states SHALL be IDLE, DRIVE and SETTLE.
REQ-017 IDLE with FIFO non-empty: at the edge, pop the head, latch the resolved op, load the counter with max(cmd_len,1), go to DRIVE. IDLE with FIFO empty: stay in IDLE, SR=00.
REQ-018 Op resolution at pop: set -> SR=10, expected Q=1; reset -> SR=01, expected Q=0; hold -> SR=00, no expectation; toggle is resolved per REQ-031/032.
REQ-019 DRIVE SHALL hold the resolved SR for exactly max(cmd_len,1) cycles, then go to SETTLE.
REQ-020 SETTLE SHALL last one cycle with SR=00; at its end the FSM compares Q_fb with the expected Q.
REQ-021 On a match, or for a hold op: pulse done in the next cycle and return to IDLE. On a mismatch: pulse err instead of done and return to IDLE.
REQ-022 SR SHALL never be 11.
REQ-023 Latency: a command pushed at edge N into an empty FIFO while IDLE SHALL drive SR from edge N+1. A second queued command SHALL start at the edge after its predecessor's done/err cycle begins (IDLE lasts one cycle between commands).
REQ-024 The counter SHALL NOT wrap: cmd_len = 2^LEN_W-1 drives for exactly that many cycles.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an extra pointer bit.

Reset
REQ-026 When rst=1 at a rising edge: FIFO empties, FSM goes to IDLE, SR=00, done=0, err=0.
REQ-027 After that edge, busy=0 and cmd_ready=0 while rst remains 1.
REQ-028 Reset during DRIVE or SETTLE SHALL abort the command with no done or err pulse; SR=00 from the next edge.
REQ-029 A push offered in the same cycle as rst SHALL be discarded.

Configuration
REQ-030 The macro SR_SEQ_TOGGLE_EN SHALL select toggle support.
REQ-031 With SR_SEQ_TOGGLE_EN defined: toggle resolves at pop to set if Q_fb=0 and to reset if Q_fb=1; the expected Q is the inverse of the sampled Q_fb.
REQ-032 Without SR_SEQ_TOGGLE_EN: a toggle op is still popped, but it drives nothing (no DRIVE/SETTLE), pulses err in the next cycle and returns to IDLE.

Verification
REQ-033 After reset, push set with len=3 and a model flop on Q_fb -> SR=10 for 3 cycles, then 00; done pulses once; err stays 0.
REQ-034 Fill the FIFO with 4 reset len=1 commands while busy -> cmd_ready goes 0 after the 4th push; all 4 complete in order, 4 done pulses, SR never 11.
REQ-035 Push set len=2 with Q_fb tied to 0 -> err pulses once after SETTLE; done does not pulse.
REQ-036 Push set len=15, assert rst in the 5th DRIVE cycle -> SR=00 from the next edge; no done or err; FIFO empty; busy=0.
REQ-037 With SR_SEQ_TOGGLE_EN and Q_fb=1, push toggle len=1 -> SR=01 for 1 cycle, then done. Without the macro -> SR stays 00 and err pulses once.
REQ-038 Push hold len=0 -> SR=00 for 1 DRIVE cycle plus SETTLE; done pulses regardless of Q_fb.
